// File: rtl/subtractor2_stream_pkg.sv
// Shared network datapath package: default widths, handshake state encoding and saturating subtract.
package subtractor2_stream_pkg;

  localparam int unsigned DWIDTH_DEFAULT = 32;
  localparam int unsigned LAYER_DEFAULT  = 15;

  // Widest operand the saturating helpers handle; callers sign-extend into this width.
  localparam int unsigned SAT_MAX_WIDTH  = 63;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  typedef struct packed {
    logic                     sat;
    logic [SAT_MAX_WIDTH-1:0] value;
  } sat_result_t;

  // a - b computed one bit wider than the operands, clamped to a signed 'width'-bit range.
  function automatic sat_result_t sat_sub(
    input logic [SAT_MAX_WIDTH-1:0] a,
    input logic [SAT_MAX_WIDTH-1:0] b,
    input int unsigned              width
  );
    logic [SAT_MAX_WIDTH:0]        one;
    logic signed [SAT_MAX_WIDTH:0] diff;
    logic signed [SAT_MAX_WIDTH:0] hi;
    logic signed [SAT_MAX_WIDTH:0] lo;
    sat_result_t                   r;
    one  = (SAT_MAX_WIDTH + 1)'(1);
    diff = $signed({a[SAT_MAX_WIDTH-1], a}) - $signed({b[SAT_MAX_WIDTH-1], b});
    hi   = $signed((one << (width - 1)) - one);
    lo   = $signed(-(one << (width - 1)));
    r.sat   = 1'b0;
    r.value = diff[SAT_MAX_WIDTH-1:0];
    if (diff > hi) begin
      r.sat   = 1'b1;
      r.value = hi[SAT_MAX_WIDTH-1:0];
    end else if (diff < lo) begin
      r.sat   = 1'b1;
      r.value = lo[SAT_MAX_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/subtractor2_stream_sat_sub.sv
// Combinational saturating a - b for DWIDTH-bit two's complement operands.
module subtractor2_stream_sat_sub
  import subtractor2_stream_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT
) (
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] diff_c,
  output logic              sat_c
);

  sat_result_t res;

  // Sign-extend into the helper's width, subtract, and narrow the clamped value back.
  always_comb begin
    res    = sat_sub(SAT_MAX_WIDTH'($signed(a)), SAT_MAX_WIDTH'($signed(b)), DWIDTH);
    diff_c = DWIDTH'(res.value);
    sat_c  = res.sat;
  end

endmodule

// File: rtl/subtractor2_stream.sv
// Streaming saturating subtractor with per-vector element index, last marker and sticky overflow.
module subtractor2_stream
  import subtractor2_stream_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEFAULT,
  parameter int unsigned Layer  = LAYER_DEFAULT
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        clr,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DWIDTH-1:0]                           a,
  input  logic [DWIDTH-1:0]                           b,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [DWIDTH-1:0]                           c,
  output logic                                        out_last,
  output logic [((Layer > 1) ? $clog2(Layer) : 1)-1:0] out_idx,
  output logic                                        ovf
);

  localparam int unsigned IDX_W = (Layer > 1) ? $clog2(Layer) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(Layer - 1);

  state_t            state;
  state_t            state_next;
  logic [IDX_W-1:0]  count;
  logic [DWIDTH-1:0] diff_c;
  logic              sat_c;
  logic              accept;
  logic              out_fire;

  subtractor2_stream_sat_sub #(
    .DWIDTH (DWIDTH)
  ) u_sat_sub (
    .a      (a),
    .b      (b),
    .diff_c (diff_c),
    .sat_c  (sat_c)
  );

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State register: EMPTY/FULL occupancy of the single output slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_EMPTY;
    else     state <= state_next;
  end

  // Next state: clr aborts, an accept always fills, a drain without refill empties.
  always_comb begin
    state_next = state;
    if (clr)           state_next = ST_EMPTY;
    else if (accept)   state_next = ST_FULL;
    else if (out_fire) state_next = ST_EMPTY;
  end

  // Handshake outputs: slot is free when empty or being drained, never during clr.
  always_comb begin
    out_valid = (state == ST_FULL);
    in_ready  = (!out_valid || out_ready) && !clr;
  end

  // Result register, element counter and per-vector sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c        <= '0;
      out_idx  <= '0;
      out_last <= 1'b0;
      ovf      <= 1'b0;
      count    <= '0;
    end else if (clr) begin
      ovf   <= 1'b0;
      count <= '0;
    end else if (accept) begin
      c        <= diff_c;
      out_idx  <= count;
      out_last <= (count == LAST_IDX);
      ovf      <= (count == '0) ? sat_c : (ovf | sat_c);
      count    <= (count == LAST_IDX) ? '0 : count + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_subtractor2_stream.sv
// Directed and scoreboarded checks for the streaming saturating subtractor.
module tb_subtractor2_stream;

  localparam int unsigned DW = 32;
  localparam int unsigned LY = 15;
  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] c;
  logic          out_last;
  logic [IW-1:0] out_idx;
  logic          ovf;

  int n_cmp;
  int n_bad;

  subtractor2_stream #(
    .DWIDTH (DW),
    .Layer  (LY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                       input logic ordy);
    in_valid  = iv;
    a         = av;
    b         = bv;
    out_ready = ordy;
  endtask

  function automatic logic [DW-1:0] ref_sub(input logic [DW-1:0] av, input logic [DW-1:0] bv);
    longint d;
    d = longint'($signed(av)) - longint'($signed(bv));
    if (d > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (d < -64'sd2147483648) return 32'h8000_0000;
    return d[DW-1:0];
  endfunction

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (c !== 32'd0) begin n_bad++; $display("FAIL reset_c got %h want 0", c); end
    n_cmp++; if (out_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", out_idx); end
    n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL reset_last got %0b want 0", out_last); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 32'(100 + i), 32'(i), 1'b1);
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid[%0d] got %0b want 1", i, out_valid); end
      n_cmp++; if (c !== 32'd100) begin n_bad++; $display("FAIL stream_c[%0d] got %0d want 100", i, c); end
      n_cmp++; if (out_idx !== 4'(i)) begin n_bad++; $display("FAIL stream_idx[%0d] got %0d want %0d", i, out_idx, i); end
      n_cmp++; if (out_last !== (i == 14)) begin n_bad++; $display("FAIL stream_last[%0d] got %0b want %0b", i, out_last, (i == 14)); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL stream_ovf[%0d] got %0b want 0", i, ovf); end
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_saturation();
    drive(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    tick();
    n_cmp++; if (c !== 32'h7FFF_FFFF) begin n_bad++; $display("FAIL sat_pos_c got %h want 7fffffff", c); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL sat_pos_ovf got %0b want 1", ovf); end
    n_cmp++; if (out_idx !== 4'd0) begin n_bad++; $display("FAIL sat_pos_idx got %0d want 0", out_idx); end
    drive(1'b1, 32'h8000_0000, 32'd1, 1'b1);
    tick();
    n_cmp++; if (c !== 32'h8000_0000) begin n_bad++; $display("FAIL sat_neg_c got %h want 80000000", c); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL sat_neg_ovf got %0b want 1", ovf); end
    for (int i = 2; i < 15; i++) begin
      drive(1'b1, 32'd7, 32'd7, 1'b1);
      tick();
    end
    n_cmp++; if (out_last !== 1'b1) begin n_bad++; $display("FAIL sat_tail_last got %0b want 1", out_last); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL sat_sticky_ovf got %0b want 1", ovf); end
    n_cmp++; if (c !== 32'd0) begin n_bad++; $display("FAIL sat_tail_c got %h want 0", c); end
    drive(1'b1, 32'd5, 32'd3, 1'b1);
    tick();
    n_cmp++; if (c !== 32'd2) begin n_bad++; $display("FAIL newvec_c got %0d want 2", c); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL newvec_ovf got %0b want 0", ovf); end
    n_cmp++; if (out_idx !== 4'd0) begin n_bad++; $display("FAIL newvec_idx got %0d want 0", out_idx); end
  endtask

  task automatic test_stall();
    drive(1'b1, 32'd10, 32'd4, 1'b0);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready got %0b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d] got %0b want 1", i, out_valid); end
      n_cmp++; if (c !== 32'd2) begin n_bad++; $display("FAIL stall_c[%0d] got %0d want 2", i, c); end
      n_cmp++; if (out_idx !== 4'd0) begin n_bad++; $display("FAIL stall_idx[%0d] got %0d want 0", i, out_idx); end
      n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL stall_ovf[%0d] got %0b want 0", i, ovf); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL unstall_in_ready got %0b want 1", in_ready); end
    tick();
    n_cmp++; if (c !== 32'd6) begin n_bad++; $display("FAIL unstall_c got %0d want 6", c); end
    n_cmp++; if (out_idx !== 4'd1) begin n_bad++; $display("FAIL unstall_idx got %0d want 1", out_idx); end
    drive(1'b0, '0, '0, 1'b1);
    tick();
  endtask

  task automatic test_clr();
    for (int i = 2; i < 8; i++) begin
      if (i == 3) drive(1'b1, 32'h8000_0000, 32'd1, 1'b1);
      else        drive(1'b1, 32'(i), 32'd0, 1'b1);
      tick();
    end
    n_cmp++; if (out_idx !== 4'd7) begin n_bad++; $display("FAIL preclr_idx got %0d want 7", out_idx); end
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL preclr_ovf got %0b want 1", ovf); end
    clr = 1'b1;
    drive(1'b1, 32'd50, 32'd1, 1'b1);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL clr_in_ready got %0b want 0", in_ready); end
    tick();
    clr = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_valid got %0b want 0", out_valid); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got %0b want 0", ovf); end
    drive(1'b1, 32'd9, 32'd4, 1'b1);
    tick();
    n_cmp++; if (c !== 32'd5) begin n_bad++; $display("FAIL postclr_c got %0d want 5", c); end
    n_cmp++; if (out_idx !== 4'd0) begin n_bad++; $display("FAIL postclr_idx got %0d want 0", out_idx); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL prerst_ovf got %0b want 1", ovf); end
    n_cmp++; if (out_idx !== 4'd1) begin n_bad++; $display("FAIL prerst_idx got %0d want 1", out_idx); end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid got %0b want 0", out_valid); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL arst_ovf got %0b want 0", ovf); end
    rst = 1'b0;
    drive(1'b1, 32'd3, 32'd1, 1'b1);
    tick();
    n_cmp++; if (c !== 32'd2) begin n_bad++; $display("FAIL restart_c got %0d want 2", c); end
    n_cmp++; if (out_idx !== 4'd0) begin n_bad++; $display("FAIL restart_idx got %0d want 0", out_idx); end
    drive(1'b0, '0, '0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_c[$];
    logic          exp_last[$];
    logic          m_valid;
    int            m_cnt;
    int            n_in;
    int            n_out;
    int            n_last;
    int            cyc;
    logic          iv;
    logic          ordy;
    logic [DW-1:0] av;
    logic [DW-1:0] bv;
    logic [DW-1:0] edge_vals[4];
    edge_vals[0] = 32'h7FFF_FFFF;
    edge_vals[1] = 32'h8000_0000;
    edge_vals[2] = 32'hFFFF_FFFF;
    edge_vals[3] = 32'h0000_0001;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    m_valid = 1'b0;
    m_cnt = 0;
    n_in = 0;
    n_out = 0;
    n_last = 0;
    cyc = 0;
    while ((n_in < 1000 || m_valid) && cyc < 6000) begin
      iv   = (n_in < 1000) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      av   = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      bv   = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
      drive(iv, av, bv, ordy);
      #1;
      n_cmp++; if (in_ready !== (!m_valid || ordy)) begin n_bad++; $display("FAIL rnd_in_ready cyc %0d got %0b want %0b", cyc, in_ready, (!m_valid || ordy)); end
      if (m_valid && ordy) begin
        n_cmp++; if (out_valid !== 1'b1 || c !== exp_c[0] || out_last !== exp_last[0]) begin
          n_bad++;
          $display("FAIL rnd_out #%0d got v=%0b c=%h last=%0b want v=1 c=%h last=%0b", n_out, out_valid, c, out_last, exp_c[0], exp_last[0]);
        end
        if (out_last === 1'b1) n_last++;
        void'(exp_c.pop_front());
        void'(exp_last.pop_front());
        n_out++;
      end
      if (iv && (!m_valid || ordy)) begin
        exp_c.push_back(ref_sub(av, bv));
        exp_last.push_back(m_cnt == LY - 1);
        m_cnt = (m_cnt == LY - 1) ? 0 : m_cnt + 1;
        n_in++;
        m_valid = 1'b1;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
      cyc++;
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    n_cmp++; if (n_out !== 1000) begin n_bad++; $display("FAIL rnd_count got %0d want 1000 (cycles %0d)", n_out, cyc); end
    n_cmp++; if (n_last !== 66) begin n_bad++; $display("FAIL rnd_last_count got %0d want 66", n_last); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    clr = 1'b0;
    drive(1'b0, '0, '0, 1'b1);
    #12;
    test_reset();
    rst = 1'b0;
    tick();
    test_stream();
    test_saturation();
    test_stall();
    test_clr();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
